// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer for the EX stage.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO. Computes the 64-bit result at
// issue and holds it internally. It then runs a fixed busy window and
// writes HI/LO when the window ends.
// Optional feature macro: MDU_MADD_EN. When defined, op 110 = MADD and
// op 111 = MSUB (signed multiply-accumulate into HI/LO with MULT latency).
// When undefined, ops 11x are reserved no-ops.
// Handshake: start is a single-cycle valid with no ready. The hazard logic
// upstream never issues start while busy is high. A start seen in RUN is
// dropped.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        d_mdu_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic        is_mul, is_div, is_mac, is_long;
  logic        load, commit;
  logic [63:0] res_d, res_q;
  logic        wr_d, wr_q;
  logic        mac_d, mac_q;
  logic        sub_d, sub_q;

  logic signed [63:0] rs_sx, rt_sx;
  logic signed [31:0] quo_s, rem_s;

  // Opcode classification; long ops occupy the busy window.
  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    is_div = (op == OP_DIV)  || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    is_mac = (op == OP_MADD) || (op == OP_MSUB);
`else
    is_mac = 1'b0;
`endif
    is_long = is_mul || is_div || is_mac;
  end

  assign load   = (state == IDLE) && start && is_long;
  assign commit = (state == RUN) && (cnt == '0);

  assign busy      = (state == RUN);
  assign stall_req = d_mdu_use && (busy || (start && is_long));

  assign rs_sx = {{32{rs[31]}}, rs};
  assign rt_sx = {{32{rt[31]}}, rt};
  assign quo_s = $signed(rs) / $signed(rt);
  assign rem_s = $signed(rs) % $signed(rt);

  // Result computed at issue time. Divide by zero clears the write flag.
  always_comb begin
    res_d = '0;
    wr_d  = 1'b1;
    mac_d = 1'b0;
    sub_d = 1'b0;
    case (op)
      OP_MULT:  res_d = rs_sx * rt_sx;
      OP_MULTU: res_d = {32'd0, rs} * {32'd0, rt};
      OP_DIV: begin
        if (rt == 32'd0) begin
          wr_d = 1'b0;
        end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
          // The quotient overflows. It wraps to the dividend and the remainder is zero.
          res_d = {32'd0, 32'h8000_0000};
        end else begin
          res_d = {rem_s, quo_s};
        end
      end
      OP_DIVU: begin
        if (rt == 32'd0) wr_d = 1'b0;
        else             res_d = {rs % rt, rs / rt};
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        res_d = rs_sx * rt_sx;
        mac_d = 1'b1;
      end
      OP_MSUB: begin
        res_d = rs_sx * rt_sx;
        mac_d = 1'b1;
        sub_d = 1'b1;
      end
`endif
      default: wr_d = 1'b0;
    endcase
  end

  // Next-state logic for the IDLE/RUN sequencer.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (start && is_long) begin
          state_d = RUN;
          cnt_d   = (is_div) ? DIV_LOAD : MULT_LOAD;
        end
      end
      RUN: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Hold the issue-time result and commit HI/LO at the end of the window.
  // MTHI and MTLO write directly from IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
      wr_q  <= 1'b0;
      mac_q <= 1'b0;
      sub_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (load) begin
        res_q <= res_d;
        wr_q  <= wr_d;
        mac_q <= mac_d;
        sub_q <= sub_d;
      end
      if (commit && wr_q) begin
        if (mac_q) begin
          {hi, lo} <= sub_q ? ({hi, lo} - res_q) : ({hi, lo} + res_q);
        end else begin
          {hi, lo} <= res_q;
        end
      end else if (state == IDLE && start && op == OP_MTHI) begin
        hi <= rs;
      end else if (state == IDLE && start && op == OP_MTLO) begin
        lo <= rs;
      end
    end
  end

  // Upstream hazard logic keeps start low while a computation is in flight.
  a_no_start_in_run: assert property (@(posedge clk) disable iff (reset)
    !(start && state == RUN));

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed literal cases plus randomized traffic for mdu_ctrl.
// A reference model tracks the remaining busy cycles and the pending HI/LO
// value using plain 64-bit arithmetic. It is compared with the DUT on every
// falling edge.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        d_mdu_use;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .d_mdu_use(d_mdu_use), .busy(busy), .stall_req(stall_req),
    .hi(hi), .lo(lo)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit is_long(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return (o != 3'b100) && (o != 3'b101);
`else
    return o < 3'd4;
`endif
  endfunction

  // Reference model: busy cycles left, pending result, and architectural HI/LO.
  bit          m_valid = 1'b0;
  int          m_left  = 0;
  bit          m_wr, m_mac, m_sub;
  logic [63:0] m_res;
  logic [63:0] m_hilo;

  // Reference model update on each rising edge.
  always @(posedge clk) begin
    longint a, b, p, q, r;
    longint unsigned ua, ub;
    a  = longint'($signed(rs));
    b  = longint'($signed(rt));
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    if (reset) begin
      m_valid = 1'b1;
      m_left  = 0;
      m_hilo  = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_wr) begin
        if (!m_mac)     m_hilo = m_res;
        else if (m_sub) m_hilo = m_hilo - m_res;
        else            m_hilo = m_hilo + m_res;
      end
    end else if (start) begin
      m_wr = 1'b1; m_mac = 1'b0; m_sub = 1'b0; m_res = '0;
      case (op)
        3'd0: begin p = a * b; m_res = p; m_left = MULT_N; end
        3'd1: begin m_res = ua * ub; m_left = MULT_N; end
        3'd2: begin
          m_left = DIV_N;
          if (rt == 0) m_wr = 1'b0;
          else begin q = a / b; r = a % b; m_res = {r[31:0], q[31:0]}; end
        end
        3'd3: begin
          m_left = DIV_N;
          if (rt == 0) m_wr = 1'b0;
          else m_res = {32'(ua % ub), 32'(ua / ub)};
        end
        3'd4: m_hilo[63:32] = rs;
        3'd5: m_hilo[31:0]  = rs;
        default: begin
`ifdef MDU_MADD_EN
          p = a * b; m_res = p; m_mac = 1'b1; m_sub = op[0]; m_left = MULT_N;
`endif
        end
      endcase
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 64'(busy), 64'(m_left > 0));
      check("stall_req", 64'(stall_req),
            64'(d_mdu_use && ((m_left > 0) || (start && is_long(op)))));
      check("hi", 64'(hi), 64'(m_hilo[63:32]));
      check("lo", 64'(lo), 64'(m_hilo[31:0]));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Driver: present a one-cycle start and return one cycle later.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    next_cycle();
    start = 1'b0;
  endtask

  // Sample busy over n+1 cycles, from the first busy cycle onward.
  task automatic count_busy(input int n, output int nb);
    nb = 0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (busy) nb++;
      next_cycle();
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    reset = 1'b1; start = 1'b0; op = '0; rs = '0; rt = '0; d_mdu_use = 1'b0;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    next_cycle();

    // MULT -3 * 7, with stall observed in the start cycle and during busy.
    d_mdu_use = 1'b1;
    start = 1'b1; op = 3'd0; rs = 32'hFFFF_FFFD; rt = 32'd7;
    @(negedge clk);
    check("stall_start_cycle", 64'(stall_req), 64'd1);
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    check("stall_busy_use", 64'(stall_req), 64'd1);
    d_mdu_use = 1'b0;
    #1;
    check("stall_busy_nouse", 64'(stall_req), 64'd0);
    count_busy(MULT_N - 1, nb);
    check("mult_busy_cycles", 64'(nb), 64'd4);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFEB);

    // DIVU 100 / 7.
    issue(3'd3, 32'd100, 32'd7);
    count_busy(DIV_N, nb);
    check("divu_busy_cycles", 64'(nb), 64'd10);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);

    // DIV -7 / 2.
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    count_busy(DIV_N, nb);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);

    // Divide by zero leaves the values written by MTHI and MTLO unchanged.
    issue(3'd4, 32'h1234, 32'd0);
    issue(3'd5, 32'h5678, 32'd0);
    issue(3'd2, 32'd99, 32'd0);
    count_busy(DIV_N, nb);
    check("div0_busy_cycles", 64'(nb), 64'd10);
    check("div0_hi", 64'(hi), 64'h1234);
    check("div0_lo", 64'(lo), 64'h5678);

    // Signed overflow case of DIV.
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(DIV_N, nb);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(hi), 64'd0);

    // Reserved opcode: no busy and no stall.
    d_mdu_use = 1'b1;
    start = 1'b1; op = 3'd6; rs = 32'd5; rt = 32'd5;
`ifndef MDU_MADD_EN
    @(negedge clk);
    check("rsvd_stall", 64'(stall_req), 64'd0);
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    check("rsvd_busy", 64'(busy), 64'd0);
    next_cycle();
`else
    start = 1'b0;
`endif
    d_mdu_use = 1'b0;

    // Reset in the third busy cycle of a MULT.
    issue(3'd4, 32'hDEAD, 32'd0);
    issue(3'd0, 32'd3, 32'd3);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    repeat (MULT_N + 2) next_cycle();
    check("midrst_no_commit", {hi, lo}, 64'd0);

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 149) == 0);
      d_mdu_use = 1'($urandom_range(0, 1));
      op        = 3'($urandom_range(0, 7));
      rs        = pick_val();
      rt        = pick_val();
      start     = (m_left == 0) && ($urandom_range(0, 2) == 0);
      next_cycle();
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (DIV_N + 2) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
